// File: rtl/mem_access_pkg.sv
// Shared RV32I memory-stage definitions: opcode encodings, FSM states, byte counts.
// Forwarding to the ID-stage bypass is built only when MEM_FWD_EN is defined.
`ifndef OpCodeLen
`define OpCodeLen 4
`endif

package mem_access_pkg;

    localparam int OP_LEN = `OpCodeLen;

    localparam logic [OP_LEN-1:0] MEM_NOP = OP_LEN'(0);
    localparam logic [OP_LEN-1:0] EX_LB   = OP_LEN'(1);
    localparam logic [OP_LEN-1:0] EX_LH   = OP_LEN'(2);
    localparam logic [OP_LEN-1:0] EX_LW   = OP_LEN'(3);
    localparam logic [OP_LEN-1:0] EX_LBU  = OP_LEN'(4);
    localparam logic [OP_LEN-1:0] EX_LHU  = OP_LEN'(5);
    localparam logic [OP_LEN-1:0] EX_SB   = OP_LEN'(6);
    localparam logic [OP_LEN-1:0] EX_SH   = OP_LEN'(7);
    localparam logic [OP_LEN-1:0] EX_SW   = OP_LEN'(8);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [2:0] NB_BYTE = 3'd1;
    localparam logic [2:0] NB_HALF = 3'd2;
    localparam logic [2:0] NB_WORD = 3'd4;

    function automatic logic is_load(input logic [OP_LEN-1:0] op);
        return (op == EX_LB) || (op == EX_LH) || (op == EX_LW) ||
               (op == EX_LBU) || (op == EX_LHU);
    endfunction

    function automatic logic is_store(input logic [OP_LEN-1:0] op);
        return (op == EX_SB) || (op == EX_SH) || (op == EX_SW);
    endfunction

    function automatic logic is_mem_op(input logic [OP_LEN-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic [2:0] byte_count(input logic [OP_LEN-1:0] op);
        logic [2:0] n;
        case (op)
            EX_LH, EX_LHU, EX_SH: n = NB_HALF;
            EX_LW, EX_SW:         n = NB_WORD;
            default:              n = NB_BYTE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of little-endian assembled load data according to the load opcode.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [OP_LEN-1:0] aluop,
    input  logic [31:0]       data,
    output logic [31:0]       ext
);

    // Select extension by access size and signedness
    always_comb begin
        ext = data;
        case (aluop)
            EX_LB:   ext = {{24{data[7]}}, data[7:0]};
            EX_LH:   ext = {{16{data[15]}}, data[15:0]};
            EX_LBU:  ext = {24'd0, data[7:0]};
            EX_LHU:  ext = {16'd0, data[15:0]};
            EX_LW:   ext = data;
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// RV32I memory stage: byte-serial loads/stores over the controller port, pipeline stall, writeback.
// Optional ID-stage forwarding outputs are enabled by defining MEM_FWD_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = `OpCodeLen,
    parameter int RA_W = 5
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [OP_W-1:0] aluop_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [RA_W-1:0] rd_addr_i,
    input  logic            rd_enable_i,
    output logic            stall_req_o,
    output logic            valid_o,
    output logic [RA_W-1:0] rd_addr_o,
    output logic            rd_enable_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [7:0]      mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [7:0]      mem_rdata_i
`ifdef MEM_FWD_EN
    ,
    output logic            fwd_en_o,
    output logic [RA_W-1:0] fwd_rd_o,
    output logic [XLEN-1:0] fwd_data_o
`endif
);

    logic [1:0]      state_r;
    logic [1:0]      k_r;
    logic [OP_W-1:0] op_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] wdata_r;
    logic [XLEN-1:0] asm_r;
    logic [RA_W-1:0] rd_r;
    logic            rden_r;
    logic [XLEN-1:0] ext_s;
    logic            last_s;

    mem_load_ext u_ext (
        .aluop (op_r),
        .data  (asm_r),
        .ext   (ext_s)
    );

    assign last_s = ({1'b0, k_r} == (byte_count(op_r) - 3'd1));

    // Memory port and stall are decoded purely from held state, so they stay stable while ack is low
    always_comb begin
        if (state_r == ST_ACCESS) begin
            mem_req_o   = 1'b1;
            mem_we_o    = is_store(op_r);
            mem_addr_o  = addr_r + {{(XLEN-2){1'b0}}, k_r};
            mem_wdata_o = is_store(op_r) ? wdata_r[{k_r, 3'b000} +: 8] : 8'd0;
        end else begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = {XLEN{1'b0}};
            mem_wdata_o = 8'd0;
        end
    end

    // Stall from the accept cycle through DONE
    always_comb begin
        if (state_r == ST_IDLE) begin
            stall_req_o = valid_i && is_mem_op(aluop_i);
        end else begin
            stall_req_o = 1'b1;
        end
    end

    // FSM, access latches, load assembly and registered writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            k_r         <= 2'd0;
            op_r        <= MEM_NOP;
            addr_r      <= {XLEN{1'b0}};
            wdata_r     <= {XLEN{1'b0}};
            asm_r       <= {XLEN{1'b0}};
            rd_r        <= {RA_W{1'b0}};
            rden_r      <= 1'b0;
            valid_o     <= 1'b0;
            rd_addr_o   <= {RA_W{1'b0}};
            rd_enable_o <= 1'b0;
            rd_data_o   <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i && is_mem_op(aluop_i)) begin
                        state_r <= ST_ACCESS;
                        k_r     <= 2'd0;
                        op_r    <= aluop_i;
                        addr_r  <= mem_addr_i;
                        wdata_r <= data_i;
                        asm_r   <= {XLEN{1'b0}};
                        rd_r    <= rd_addr_i;
                        rden_r  <= rd_enable_i;
                        valid_o <= 1'b0;
                    end else if (valid_i) begin
                        valid_o     <= 1'b1;
                        rd_addr_o   <= rd_addr_i;
                        rd_enable_o <= rd_enable_i;
                        rd_data_o   <= data_i;
                    end else begin
                        valid_o <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    valid_o <= 1'b0;
                    if (mem_ack_i) begin
                        if (is_load(op_r)) begin
                            asm_r[{k_r, 3'b000} +: 8] <= mem_rdata_i;
                        end else begin
                            asm_r <= asm_r;
                        end
                        if (last_s) begin
                            state_r <= ST_DONE;
                            k_r     <= 2'd0;
                        end else begin
                            k_r <= k_r + 2'd1;
                        end
                    end else begin
                        k_r <= k_r;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    valid_o   <= 1'b1;
                    rd_addr_o <= rd_r;
                    if (is_load(op_r)) begin
                        rd_enable_o <= rden_r;
                        rd_data_o   <= ext_s;
                    end else begin
                        rd_enable_o <= 1'b0;
                        rd_data_o   <= {XLEN{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_FWD_EN
    // Bypass toward ID: ALU results in IDLE, extended load data in DONE
    always_comb begin
        if ((state_r == ST_IDLE) && valid_i && !is_mem_op(aluop_i) && rd_enable_i) begin
            fwd_en_o   = 1'b1;
            fwd_rd_o   = rd_addr_i;
            fwd_data_o = data_i;
        end else if ((state_r == ST_DONE) && is_load(op_r)) begin
            fwd_en_o   = 1'b1;
            fwd_rd_o   = rd_r;
            fwd_data_o = ext_s;
        end else begin
            fwd_en_o   = 1'b0;
            fwd_rd_o   = {RA_W{1'b0}};
            fwd_data_o = {XLEN{1'b0}};
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access; covers the forwarding outputs when MEM_FWD_EN is defined.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [3:0]  aluop_i = 4'd0;
    logic [31:0] mem_addr_i = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic [4:0]  rd_addr_i = 5'd0;
    logic        rd_enable_i = 1'b0;
    logic        stall_req_o, valid_o, rd_enable_o, mem_req_o, mem_we_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o, mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [7:0]  mem_rdata_i = 8'd0;
`ifdef MEM_FWD_EN
    logic        fwd_en_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .aluop_i(aluop_i),
        .mem_addr_i(mem_addr_i), .data_i(data_i), .rd_addr_i(rd_addr_i),
        .rd_enable_i(rd_enable_i), .stall_req_o(stall_req_o), .valid_o(valid_o),
        .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o), .rd_data_o(rd_data_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
`ifdef MEM_FWD_EN
        , .fwd_en_o(fwd_en_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o)
`endif
    );

    // Issue one load/store and act as the memory controller until valid_o appears
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic [31:0] rbytes, input int wait_first,
                          output int lat, output int stall_n, output int nb,
                          output logic [127:0] alog, output logic [31:0] wlog,
                          output logic [3:0] we_log, output logic hold_ok, output logic end_stall);
        int w;
        logic waited;
        logic [31:0] held_a;
        logic [7:0] held_d;
        w = wait_first; waited = 1'b0; held_a = 32'd0; held_d = 8'd0;
        nb = 0; alog = 128'd0; wlog = 32'd0; we_log = 4'd0; hold_ok = 1'b1;
        stall_n = 0; lat = 0;
        @(negedge clk);
        valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; data_i = data;
        rd_addr_i = rd; rd_enable_i = 1'b1;
        #1;
        if (stall_req_o) stall_n++;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; aluop_i = MEM_NOP;
        lat = 1;
        while (!valid_o && lat < 40) begin
            if (stall_req_o) stall_n++;
            mem_ack_i = 1'b0; mem_rdata_i = 8'd0;
            if (mem_req_o) begin
                if (waited && (mem_addr_o !== held_a || mem_wdata_o !== held_d)) hold_ok = 1'b0;
                if (w > 0) begin
                    held_a = mem_addr_o; held_d = mem_wdata_o; waited = 1'b1; w--;
                end else if (nb < 4) begin
                    waited = 1'b0;
                    mem_ack_i = 1'b1;
                    mem_rdata_i = rbytes[8*nb +: 8];
                    alog[32*nb +: 32] = mem_addr_o;
                    wlog[8*nb +: 8] = mem_wdata_o;
                    we_log[nb] = mem_we_o;
                    nb++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        mem_ack_i = 1'b0;
        end_stall = stall_req_o;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({valid_o, rd_enable_o, mem_req_o, mem_we_o, stall_req_o} !== 5'd0 ||
            rd_addr_o !== 5'd0 || rd_data_o !== 32'd0 || mem_addr_o !== 32'd0 || mem_wdata_o !== 8'd0) begin
            errors++;
            $display("FAIL reset: valid=%b rd=%h data=%h req=%b stall=%b, expected all zero",
                     valid_o, rd_addr_o, rd_data_o, mem_req_o, stall_req_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_pass();
        @(negedge clk);
        valid_i = 1'b1; aluop_i = MEM_NOP; rd_addr_i = 5'd5; rd_enable_i = 1'b1; data_i = 32'h1234;
        #1;
        checks++;
        if (stall_req_o !== 1'b0 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL nop_stall: stall=%b req=%b expected 0 0", stall_req_o, mem_req_o);
        end
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_enable_o !== 1'b1 || rd_data_o !== 32'h00001234) begin
            errors++;
            $display("FAIL nop_result: valid=%b rd=%0d en=%b data=%h expected 1 5 1 00001234",
                     valid_o, rd_addr_o, rd_enable_o, rd_data_o);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || rd_data_o !== 32'h00001234 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL nop_pulse_hold: valid=%b data=%h req=%b expected 0 00001234 0",
                     valid_o, rd_data_o, mem_req_o);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        valid_i = 1'b1; aluop_i = MEM_NOP; rd_addr_i = 5'd1; rd_enable_i = 1'b1; data_i = 32'hAAAA0001;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || rd_addr_o !== 5'd1 || rd_data_o !== 32'hAAAA0001) begin
            errors++;
            $display("FAIL b2b_first: valid=%b rd=%0d data=%h expected 1 1 aaaa0001", valid_o, rd_addr_o, rd_data_o);
        end
        aluop_i = 4'hF; rd_addr_i = 5'd9; rd_enable_i = 1'b0; data_i = 32'h0000DEAD;
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            errors++;
            $display("FAIL unknown_op_stall: stall=%b expected 0", stall_req_o);
        end
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || rd_addr_o !== 5'd9 || rd_enable_o !== 1'b0 || rd_data_o !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL unknown_op_result: valid=%b rd=%0d en=%b data=%h expected 1 9 0 0000dead",
                     valid_o, rd_addr_o, rd_enable_o, rd_data_o);
        end
    endtask

    task automatic test_lw();
        int lat, st, nb;
        logic [127:0] al;
        logic [31:0] wl;
        logic [3:0] we;
        logic hold, es;
        run_op(EX_LW, 32'h100, 32'h0, 5'd10, 32'h12345678, 0, lat, st, nb, al, wl, we, hold, es);
        checks++;
        if (al !== {32'h103, 32'h102, 32'h101, 32'h100} || nb !== 4 || we !== 4'b0000) begin
            errors++;
            $display("FAIL lw_addr: addrs=%h n=%0d we=%b expected 00000103_00000102_00000101_00000100 4 0000", al, nb, we);
        end
        checks++;
        if (lat !== 6 || st !== 6 || es !== 1'b0) begin
            errors++;
            $display("FAIL lw_timing: latency=%0d stall_cycles=%0d stall_at_result=%b expected 6 6 0", lat, st, es);
        end
        checks++;
        if (valid_o !== 1'b1 || rd_data_o !== 32'h12345678 || rd_addr_o !== 5'd10 || rd_enable_o !== 1'b1) begin
            errors++;
            $display("FAIL lw_data: valid=%b data=%h rd=%0d en=%b expected 1 12345678 10 1",
                     valid_o, rd_data_o, rd_addr_o, rd_enable_o);
        end
    endtask

    task automatic test_ext();
        int lat, st, nb;
        logic [127:0] al;
        logic [31:0] wl;
        logic [3:0] we;
        logic hold, es;
        run_op(EX_LB, 32'h7, 32'h0, 5'd2, 32'h00000080, 0, lat, st, nb, al, wl, we, hold, es);
        checks++;
        if (rd_data_o !== 32'hFFFFFF80 || al[31:0] !== 32'h7 || lat !== 3) begin
            errors++;
            $display("FAIL lb: data=%h addr=%h latency=%0d expected ffffff80 00000007 3", rd_data_o, al[31:0], lat);
        end
        run_op(EX_LBU, 32'h7, 32'h0, 5'd2, 32'h00000080, 0, lat, st, nb, al, wl, we, hold, es);
        checks++;
        if (rd_data_o !== 32'h00000080) begin
            errors++;
            $display("FAIL lbu: data=%h expected 00000080", rd_data_o);
        end
        run_op(EX_LH, 32'h3, 32'h0, 5'd4, 32'h00009001, 0, lat, st, nb, al, wl, we, hold, es);
        checks++;
        if (rd_data_o !== 32'hFFFF9001 || al[63:0] !== {32'h4, 32'h3} || nb !== 2) begin
            errors++;
            $display("FAIL lh: data=%h addrs=%h n=%0d expected ffff9001 00000004_00000003 2", rd_data_o, al[63:0], nb);
        end
        run_op(EX_LHU, 32'h3, 32'h0, 5'd4, 32'h00009001, 0, lat, st, nb, al, wl, we, hold, es);
        checks++;
        if (rd_data_o !== 32'h00009001) begin
            errors++;
            $display("FAIL lhu: data=%h expected 00009001", rd_data_o);
        end
    endtask

    task automatic test_store_wrap();
        int lat, st, nb;
        logic [127:0] al;
        logic [31:0] wl;
        logic [3:0] we;
        logic hold, es;
        run_op(EX_SH, 32'hFFFFFFFF, 32'h0000ABCD, 5'd6, 32'h0, 3, lat, st, nb, al, wl, we, hold, es);
        checks++;
        if (al[63:0] !== {32'h0, 32'hFFFFFFFF} || wl[15:0] !== 16'hABCD || we[1:0] !== 2'b11 || nb !== 2) begin
            errors++;
            $display("FAIL sh_bytes: addrs=%h wdata=%h we=%b n=%0d expected 00000000_ffffffff abcd 11 2",
                     al[63:0], wl[15:0], we[1:0], nb);
        end
        checks++;
        if (hold !== 1'b1 || lat !== 7 || st !== 7) begin
            errors++;
            $display("FAIL sh_wait: hold_stable=%b latency=%0d stall_cycles=%0d expected 1 7 7", hold, lat, st);
        end
        checks++;
        if (valid_o !== 1'b1 || rd_enable_o !== 1'b0 || rd_data_o !== 32'h0 || rd_addr_o !== 5'd6) begin
            errors++;
            $display("FAIL sh_result: valid=%b en=%b data=%h rd=%0d expected 1 0 00000000 6",
                     valid_o, rd_enable_o, rd_data_o, rd_addr_o);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EX_SW; mem_addr_i = 32'h200; data_i = 32'h11223344;
        rd_addr_i = 5'd3; rd_enable_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; aluop_i = MEM_NOP;
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h201 || mem_wdata_o !== 8'h33) begin
            errors++;
            $display("FAIL sw_byte2: req=%b addr=%h wdata=%h expected 1 00000201 33", mem_req_o, mem_addr_o, mem_wdata_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || stall_req_o !== 1'b0 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: req=%b stall=%b we=%b expected 0 0 0", mem_req_o, stall_req_o, mem_we_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        valid_i = 1'b1; aluop_i = MEM_NOP; rd_addr_i = 5'd7; rd_enable_i = 1'b1; data_i = 32'hCAFE;
        @(negedge clk);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || rd_addr_o !== 5'd7 || rd_data_o !== 32'h0000CAFE || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_nop: valid=%b rd=%0d data=%h req=%b expected 1 7 0000cafe 0",
                     valid_o, rd_addr_o, rd_data_o, mem_req_o);
        end
    endtask

`ifdef MEM_FWD_EN
    task automatic test_forward();
        @(negedge clk);
        valid_i = 1'b1; aluop_i = MEM_NOP; rd_addr_i = 5'd3; rd_enable_i = 1'b1; data_i = 32'h55;
        #1;
        checks++;
        if (fwd_en_o !== 1'b1 || fwd_rd_o !== 5'd3 || fwd_data_o !== 32'h55) begin
            errors++;
            $display("FAIL fwd_nop: en=%b rd=%0d data=%h expected 1 3 00000055", fwd_en_o, fwd_rd_o, fwd_data_o);
        end
        @(negedge clk);
        aluop_i = EX_LB; mem_addr_i = 32'h20; rd_addr_i = 5'd8;
        @(negedge clk);
        valid_i = 1'b0; aluop_i = MEM_NOP;
        checks++;
        if (fwd_en_o !== 1'b0 || fwd_data_o !== 32'h0) begin
            errors++;
            $display("FAIL fwd_access: en=%b data=%h expected 0 00000000", fwd_en_o, fwd_data_o);
        end
        mem_ack_i = 1'b1; mem_rdata_i = 8'hF0;
        @(negedge clk);
        mem_ack_i = 1'b0; mem_rdata_i = 8'h00;
        checks++;
        if (fwd_en_o !== 1'b1 || fwd_rd_o !== 5'd8 || fwd_data_o !== 32'hFFFFFFF0) begin
            errors++;
            $display("FAIL fwd_done: en=%b rd=%0d data=%h expected 1 8 fffffff0", fwd_en_o, fwd_rd_o, fwd_data_o);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_alu_pass();
        test_back_to_back();
        test_lw();
        test_ext();
        test_store_wrap();
        test_reset_mid_access();
`ifdef MEM_FWD_EN
        test_forward();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
